// File: rtl/wb_ic_pkg.sv
// Shared types and width helpers for the single-master Wishbone interconnect.
package wb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  // Target index is wide enough for up to 8 slaves plus a distinct "none" code.
  localparam int TGT_W = 4;
  localparam logic [TGT_W-1:0] TGT_NONE = 4'hF;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic int wdog_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Priority base/mask address decoder: lowest matching slot index wins.
module wb_addr_decode
  import wb_ic_pkg::*;
#(
  parameter int                           NUM_SLAVES = 3,
  parameter int                           ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic [TGT_W-1:0]  index
);

  always_comb begin
    valid = 1'b0;
    index = TGT_NONE;
    // Walk downwards so the lowest matching index is the last one written.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        valid = 1'b1;
        index = TGT_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, N-slave pipelined Wishbone B4 interconnect with in-order
// response routing, unmapped-address errors and a hung-slave watchdog.
module wb_interconnect
  import wb_ic_pkg::*;
#(
  parameter int                           NUM_SLAVES      = 3,
  parameter int                           ADDR_W          = 32,
  parameter int                           DATA_W          = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE      = {32'h0000_0000, 32'h0200_0004, 32'h0200_0008},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK      = {32'hFF00_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
  parameter int                           MAX_OUTSTANDING = 4,
  parameter int                           TIMEOUT_CYCLES  = 255,
  localparam int                          SEL_W           = DATA_W / 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_master_cyc,
  input  logic                         i_master_stb,
  input  logic                         i_master_we,
  input  logic [ADDR_W-1:0]            i_master_addr,
  input  logic [DATA_W-1:0]            i_master_data,
  input  logic [SEL_W-1:0]             i_master_sel,
  output logic                         o_master_stall,
  output logic                         o_master_ack,
  output logic                         o_master_err,
  output logic [DATA_W-1:0]            o_master_data,
  output logic [NUM_SLAVES-1:0]        o_slave_cyc,
  output logic [NUM_SLAVES-1:0]        o_slave_stb,
  output logic [NUM_SLAVES-1:0]        o_slave_we,
  output logic [NUM_SLAVES*ADDR_W-1:0] o_slave_addr,
  output logic [NUM_SLAVES*DATA_W-1:0] o_slave_data,
  output logic [NUM_SLAVES*SEL_W-1:0]  o_slave_sel,
  input  logic [NUM_SLAVES-1:0]        i_slave_stall,
  input  logic [NUM_SLAVES-1:0]        i_slave_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_slave_data,
  output state_t                       o_dbg_state
);

  localparam int               CNT_W   = cnt_width(MAX_OUTSTANDING);
  localparam int               WD_W    = wdog_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TGT_W-1:0]    active_q;
  logic [WD_W-1:0]     wdog_q;
  logic                ack_q, err_q, unmap_q;
  logic [DATA_W-1:0]   data_q;

  logic                dec_valid;
  logic [TGT_W-1:0]    dec_idx, target;
  logic                tgt_stall, act_ack;
  logic [DATA_W-1:0]   act_data;
  logic                block, accept, busy, drop;
  logic                resp_slave, resp_none, any_resp, abort_go;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr  (i_master_addr),
    .valid (dec_valid),
    .index (dec_idx)
  );

  assign target = dec_valid ? dec_idx : TGT_NONE;

  always_comb begin
    tgt_stall = 1'b0;
    act_ack   = 1'b0;
    act_data  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dec_valid && dec_idx == TGT_W'(i)) tgt_stall = i_slave_stall[i];
      if (active_q == TGT_W'(i)) begin
        act_ack  = i_slave_ack[i];
        act_data = i_slave_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Handshake: a request transfers on a cycle where cyc & stb & !stall; every
  // transferred request gets exactly one ack or err, in issue order, unless
  // the cycle is dropped, the watchdog aborts, or reset intervenes.
  assign block = !i_rst || (cnt_q == CNT_MAX) || (cnt_q != '0 && target != active_q)
              || (state_q == ABORT);
  assign o_master_stall = block || tgt_stall;
  assign accept         = i_master_cyc && i_master_stb && !o_master_stall;
  assign busy           = (cnt_q != '0);
  assign drop           = !i_master_cyc && busy;
  assign resp_slave     = busy && act_ack && i_master_cyc;
  assign resp_none      = busy && unmap_q && (active_q == TGT_NONE);
  assign any_resp       = resp_slave || resp_none;
  assign abort_go       = (state_q == BUSY) && !any_resp && !drop && (wdog_q == WD_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (drop || abort_go) cnt_d = '0;
    else if (accept && !any_resp) cnt_d = cnt_q + CNT_W'(1);
    else if (!accept && any_resp) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY: begin
        if (drop)              state_d = IDLE;
        else if (abort_go)     state_d = ABORT;
        else if (cnt_d == '0)  state_d = IDLE;
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_slave_stb = '0;
    o_slave_cyc = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_slave_stb[i] = i_master_stb && dec_valid && (dec_idx == TGT_W'(i)) && !block;
      o_slave_cyc[i] = i_master_cyc && i_rst && (state_q != ABORT)
                    && ((active_q == TGT_W'(i)) || o_slave_stb[i]);
    end
  end

  assign o_slave_we   = {NUM_SLAVES{i_master_we}};
  assign o_slave_addr = {NUM_SLAVES{i_master_addr}};
  assign o_slave_data = {NUM_SLAVES{i_master_data}};
  assign o_slave_sel  = {NUM_SLAVES{i_master_sel}};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= TGT_NONE;
      wdog_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      unmap_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) active_q <= target;
      if (state_q != BUSY || any_resp || drop || abort_go) wdog_q <= '0;
      else wdog_q <= wdog_q + WD_W'(1);
      ack_q   <= resp_slave;
      data_q  <= resp_slave ? act_data : '0;
      unmap_q <= accept && !dec_valid;
      err_q   <= (accept && !dec_valid) || abort_go;
    end
  end

  assign o_master_ack  = ack_q;
  assign o_master_err  = err_q;
  assign o_master_data = data_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: reset, single read, burst with target
// switch, unmapped write, watchdog abort, cycle drop and mid-flight reset.
module tb_wb_interconnect;
  import wb_ic_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_sel;
  logic        m_stall, m_ack, m_err;
  logic [31:0] m_rdata;
  logic [2:0]  s_cyc, s_stb, s_we;
  logic [95:0] s_addr, s_wdata;
  logic [11:0] s_sel;
  logic [2:0]  s_stall, s_ack;
  logic [95:0] s_rdata;
  state_t      dbg_state;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acks;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  wb_interconnect #(.TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_master_cyc(m_cyc), .i_master_stb(m_stb), .i_master_we(m_we),
    .i_master_addr(m_addr), .i_master_data(m_wdata), .i_master_sel(m_sel),
    .o_master_stall(m_stall), .o_master_ack(m_ack), .o_master_err(m_err),
    .o_master_data(m_rdata),
    .o_slave_cyc(s_cyc), .o_slave_stb(s_stb), .o_slave_we(s_we),
    .o_slave_addr(s_addr), .o_slave_data(s_wdata), .o_slave_sel(s_sel),
    .i_slave_stall(s_stall), .i_slave_ack(s_ack), .i_slave_data(s_rdata),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, want done)");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] a, input logic w);
    m_stb  = 1'b1;
    m_addr = a;
    m_we   = w;
  endtask

  initial begin
    rst = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
    m_addr = 32'h0200_0004; m_wdata = 32'h1234_5678; m_sel = 4'hF;
    s_stall = '0; s_ack = '0; s_rdata = '0;

    // 1: reset held with a live strobe
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      check("rst_slave_cyc", 32'(s_cyc), 32'h0);
      check("rst_slave_stb", 32'(s_stb), 32'h0);
      check("rst_ack", 32'(m_ack), 32'h0);
      check("rst_err", 32'(m_err), 32'h0);
      check("rst_data", m_rdata, 32'h0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
    end
    next_cycle();
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    next_cycle();

    // 2: single LED read, first held off by slave stall
    m_cyc = 1'b1; drive_req(32'h0200_0004, 1'b0); s_stall = 3'b010;
    sample();
    check("t2_slave_stall", 32'(m_stall), 32'h1);
    check("t2_stb_stalled", 32'(s_stb), 32'h2);
    next_cycle();
    s_stall = 3'b000;
    sample();
    check("t2_stall", 32'(m_stall), 32'h0);
    check("t2_stb", 32'(s_stb), 32'h2);
    check("t2_cyc", 32'(s_cyc), 32'h2);
    check("t2_bcast_addr", s_addr[64 +: 32], 32'h0200_0004);
    next_cycle();
    m_stb = 1'b0; s_ack = 3'b010; s_rdata[32 +: 32] = 32'h0000_00A5;
    sample();
    check("t2_ack_early", 32'(m_ack), 32'h0);
    check("t2_stb_once", 32'(s_stb), 32'h0);
    check("t2_state_busy", 32'(dbg_state), 32'(BUSY));
    next_cycle();
    s_ack = 3'b000;
    sample();
    check("t2_ack", 32'(m_ack), 32'h1);
    check("t2_data", m_rdata, 32'h0000_00A5);
    check("t2_err", 32'(m_err), 32'h0);
    check("t2_state_idle", 32'(dbg_state), 32'(IDLE));
    next_cycle();
    sample();
    check("t2_ack_gone", 32'(m_ack), 32'h0);
    next_cycle();

    // 3: four mem reads acked four cycles after issue, then a UART read
    n_acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 4) drive_req(32'h0000_0010 + 32'(4 * i), 1'b0);
      else if (i <= 8) drive_req(32'h0200_0008, 1'b0);
      else m_stb = 1'b0;
      s_ack = 3'b000;
      if (i >= 4 && i <= 7) begin
        s_ack[2] = 1'b1;
        s_rdata[64 +: 32] = 32'hDA7A_0000 | (32'h0000_0010 + 32'(4 * (i - 4)));
        exp_q.push_back(s_rdata[64 +: 32]);
      end
      if (i == 9) begin
        s_ack[0] = 1'b1;
        s_rdata[0 +: 32] = 32'h0000_0055;
        exp_q.push_back(32'h0000_0055);
      end
      sample();
      if (m_ack) begin
        n_acks++;
        if (exp_q.size() == 0) check("t3_unexpected_ack", 32'(m_ack), 32'h0);
        else begin
          exp_v = exp_q.pop_front();
          check("t3_rdata", m_rdata, exp_v);
        end
      end
      if (i < 4) begin
        check("t3_no_stall", 32'(m_stall), 32'h0);
        check("t3_stb_mem", 32'(s_stb), 32'h4);
      end else if (i <= 7) begin
        check("t3_stall_drain", 32'(m_stall), 32'h1);
        check("t3_stb_held", 32'(s_stb), 32'h0);
      end else if (i == 8) begin
        check("t3_switch_go", 32'(m_stall), 32'h0);
        check("t3_stb_uart", 32'(s_stb), 32'h1);
      end
      next_cycle();
    end
    s_ack = 3'b000;
    check("t3_ack_total", 32'(n_acks), 32'd5);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: unmapped write
    drive_req(32'h0300_0000, 1'b1);
    sample();
    check("t4_no_stb", 32'(s_stb), 32'h0);
    check("t4_no_stall", 32'(m_stall), 32'h0);
    check("t4_err_early", 32'(m_err), 32'h0);
    check("t4_bcast_we", 32'(s_we), 32'h7);
    next_cycle();
    m_stb = 1'b0; m_we = 1'b0;
    sample();
    check("t4_err", 32'(m_err), 32'h1);
    check("t4_err_data", m_rdata, 32'h0);
    check("t4_no_ack", 32'(m_ack), 32'h0);
    check("t4_state_busy", 32'(dbg_state), 32'(BUSY));
    next_cycle();
    sample();
    check("t4_err_once", 32'(m_err), 32'h0);
    check("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    check("t4_cyc_none", 32'(s_cyc), 32'h0);
    next_cycle();

    // 5: watchdog abort on a mem read that never acks
    drive_req(32'h0000_0020, 1'b0);
    sample();
    check("t5_stb", 32'(s_stb), 32'h4);
    next_cycle();
    m_stb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      sample();
      check("t5_wait_err", 32'(m_err), 32'h0);
      check("t5_wait_state", 32'(dbg_state), 32'(BUSY));
      next_cycle();
    end
    sample();
    check("t5_abort_err", 32'(m_err), 32'h1);
    check("t5_abort_cyc", 32'(s_cyc), 32'h0);
    check("t5_abort_state", 32'(dbg_state), 32'(ABORT));
    next_cycle();
    sample();
    check("t5_err_once", 32'(m_err), 32'h0);
    check("t5_idle", 32'(dbg_state), 32'(IDLE));
    check("t5_cyc_back", 32'(s_cyc), 32'h4);
    next_cycle();
    s_ack = 3'b100;
    next_cycle();
    s_ack = 3'b000;
    sample();
    check("t5_late_ack", 32'(m_ack), 32'h0);
    check("t5_late_err", 32'(m_err), 32'h0);
    next_cycle();

    // 6a: master drops cyc with two reads outstanding
    drive_req(32'h0000_0030, 1'b0);
    next_cycle();
    drive_req(32'h0000_0034, 1'b0);
    sample();
    check("t6a_second_go", 32'(m_stall), 32'h0);
    next_cycle();
    m_cyc = 1'b0; m_stb = 1'b0;
    sample();
    check("t6a_cyc_drop", 32'(s_cyc), 32'h0);
    next_cycle();
    s_ack = 3'b100;
    sample();
    check("t6a_state", 32'(dbg_state), 32'(IDLE));
    check("t6a_ack0", 32'(m_ack), 32'h0);
    next_cycle();
    m_cyc = 1'b1;
    sample();
    check("t6a_ack1", 32'(m_ack), 32'h0);
    check("t6a_err1", 32'(m_err), 32'h0);
    next_cycle();
    s_ack = 3'b000;
    sample();
    check("t6a_ack2", 32'(m_ack), 32'h0);
    check("t6a_err2", 32'(m_err), 32'h0);
    next_cycle();

    // 6b: reset with two reads outstanding
    drive_req(32'h0000_0040, 1'b0);
    next_cycle();
    drive_req(32'h0000_0044, 1'b0);
    next_cycle();
    m_stb = 1'b0; rst = 1'b0; s_ack = 3'b100;
    sample();
    check("t6b_rst_cyc", 32'(s_cyc), 32'h0);
    next_cycle();
    rst = 1'b1;
    sample();
    check("t6b_ack0", 32'(m_ack), 32'h0);
    check("t6b_err0", 32'(m_err), 32'h0);
    check("t6b_data0", m_rdata, 32'h0);
    check("t6b_state0", 32'(dbg_state), 32'(IDLE));
    next_cycle();
    s_ack = 3'b000;
    sample();
    check("t6b_ack1", 32'(m_ack), 32'h0);
    check("t6b_state1", 32'(dbg_state), 32'(IDLE));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
